// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-to-read bypass and a
// per-register pending-write scoreboard for hazard detection.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int CNT_W = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                wb_retire,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  output logic                err_underflow
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [CNT_W-1:0] cnt_q  [NREGS];
  logic [CNT_W-1:0] cnt_d  [NREGS];
  logic             err_q, err_d;
  logic             ret, issue_acc;

  // A retire to a saturated register frees the slot in the same cycle
  always_comb begin
    ret         = we && wb_retire && (wa != '0);
    issue_ready = (issue_rd == '0)
               || (cnt_q[issue_rd] != CMAX)
               || (ret && (wa == issue_rd));
    issue_acc   = issue_valid && issue_ready;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[i*AW +: AW];
    assign rd_data[i*XLEN +: XLEN] =
      (a == '0)             ? '0 :
      (we && (wa == a))     ? wd :
                              regs_q[a];
    // Last pending value arriving now is covered by the bypass
    assign rd_busy[i] = (a != '0)
                     && (cnt_q[a] != '0)
                     && !((cnt_q[a] == CONE) && ret && (wa == a));
  end

  always_comb begin
    err_d    = err_q;
    cnt_d[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue_acc && (issue_rd == AW'(r))
          && !(ret && (wa == AW'(r)))) begin
        cnt_d[r] = cnt_q[r] + CONE;
      end else if (ret && (wa == AW'(r))
          && !(issue_acc && (issue_rd == AW'(r)))) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - CONE;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (we && (wa != '0)) begin
        regs_q[wa] <= wd;
      end
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  assign err_underflow = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: spec-level model checked every cycle,
// directed vectors with literal expectations, plus a 3-port 64-bit build.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we, wb_retire, issue_valid;
  logic [4:0]  wa, issue_rd;
  logic [31:0] wd;
  logic        issue_ready, err_underflow;

  logic [14:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic         b_we, b_wb_retire, b_issue_valid;
  logic [4:0]   b_wa, b_issue_rd;
  logic [63:0]  b_wd;
  logic         b_issue_ready, b_err;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .wb_retire(wb_retire),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .err_underflow(err_underflow)
  );

  regfile_scoreboard #(.XLEN(64), .NRD(3)) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .we(b_we), .wa(b_wa), .wd(b_wd), .wb_retire(b_wb_retire),
    .issue_valid(b_issue_valid), .issue_rd(b_issue_rd),
    .issue_ready(b_issue_ready), .err_underflow(b_err)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Model: pending count per register as plain integers
  int          m_cnt [32];
  logic [31:0] m_reg [32];
  bit          m_err;

  function automatic bit m_ret();
    return we && wb_retire && (wa != 0);
  endfunction

  function automatic bit m_rdy();
    if (issue_rd == 0) return 1'b1;
    if (m_cnt[issue_rd] < 3) return 1'b1;
    return m_ret() && (wa == issue_rd);
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_cnt[r] = 0;
        m_reg[r] = '0;
      end
      m_err = 1'b0;
    end else begin
      bit acc;
      acc = issue_valid && m_rdy();
      for (int r = 1; r < 32; r++) begin
        int d;
        d = ((acc && issue_rd == r) ? 1 : 0)
          - ((m_ret() && wa == r) ? 1 : 0);
        if (m_cnt[r] + d < 0) m_err = 1'b1;
        else m_cnt[r] = m_cnt[r] + d;
      end
      if (we && wa != 0) m_reg[wa] = wd;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [4:0]  a;
        logic [31:0] ed;
        bit          eb;
        a  = rd_addr[i*5 +: 5];
        ed = (a == 0) ? 32'h0 : (we && wa == a) ? wd : m_reg[a];
        eb = (a != 0) && (m_cnt[a] != 0)
          && !(m_cnt[a] == 1 && m_ret() && wa == a);
        chk($sformatf("model_rd_data%0d", i),
            64'(rd_data[i*32 +: 32]), 64'(ed));
        chk($sformatf("model_rd_busy%0d", i),
            64'(rd_busy[i]), 64'(eb));
      end
      chk("model_issue_ready", 64'(issue_ready), 64'(m_rdy()));
      chk("model_err", 64'(err_underflow), 64'(m_err));
    end
  end

  task automatic idle();
    we = 0; wb_retire = 0; issue_valid = 0;
    wa = 0; wd = 0; issue_rd = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic bop(bit iv, logic [4:0] ir, bit rv,
                     logic [4:0] a, logic [63:0] d);
    b_issue_valid = iv; b_issue_rd = ir;
    b_we = rv; b_wb_retire = rv; b_wa = a; b_wd = d;
    nxt();
  endtask

  initial begin
    rst = 1; rd_addr = '0; idle();
    b_rd_addr = {5'd6, 5'd4, 5'd3};
    b_we = 0; b_wb_retire = 0; b_issue_valid = 0;
    b_wa = 0; b_issue_rd = 0; b_wd = '0;
    nxt(); nxt();
    rst = 0; chk_en = 1;

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      @(negedge clk);
      chk("reset_rd_data", rd_data, 64'h0);
      chk("reset_rd_busy", 64'(rd_busy), 64'h0);
      nxt();
    end
    chk("reset_ready", 64'(issue_ready), 64'h1);
    chk("reset_err", 64'(err_underflow), 64'h0);

    we = 1; wa = 5; wd = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    chk("bypass", 64'(rd_data[31:0]), 64'hDEADBEEF);
    nxt(); idle();
    @(negedge clk);
    chk("stored", 64'(rd_data[31:0]), 64'hDEADBEEF);
    nxt();
    we = 1; wa = 0; wd = 32'h1234; rd_addr = {5'd0, 5'd0};
    @(negedge clk);
    chk("x0_bypass", 64'(rd_data[31:0]), 64'h0);
    nxt(); idle();
    @(negedge clk);
    chk("x0_stored", 64'(rd_data[31:0]), 64'h0);
    nxt();

    rd_addr = {5'd7, 5'd0};
    issue_valid = 1; issue_rd = 7;
    @(negedge clk);
    chk("issue_no_busy", 64'(rd_busy[1]), 64'h0);
    nxt(); nxt(); nxt();
    @(negedge clk);
    chk("full_not_ready", 64'(issue_ready), 64'h0);
    chk("full_busy", 64'(rd_busy[1]), 64'h1);
    we = 1; wb_retire = 1; wa = 7; wd = 32'h77;
    @(negedge clk);
    chk("full_retire_ready", 64'(issue_ready), 64'h1);
    nxt();
    we = 0; wb_retire = 0;
    @(negedge clk);
    chk("full_still3", 64'(issue_ready), 64'h0);
    nxt(); idle();

    issue_valid = 1; issue_rd = 9;
    nxt(); idle();
    rd_addr = {5'd9, 5'd0};
    we = 1; wb_retire = 1; wa = 9; wd = 32'h55;
    @(negedge clk);
    chk("last_busy", 64'(rd_busy[1]), 64'h0);
    chk("last_data", 64'(rd_data[63:32]), 64'h55);
    nxt(); idle();
    @(negedge clk);
    chk("drained_busy", 64'(rd_busy[1]), 64'h0);
    chk("drained_data", 64'(rd_data[63:32]), 64'h55);
    nxt();

    issue_valid = 1; issue_rd = 0;
    we = 1; wb_retire = 1; wa = 0; wd = 32'hABC;
    nxt(); idle();
    issue_valid = 1; issue_rd = 13;
    we = 1; wb_retire = 1; wa = 13; wd = 32'h13;
    rd_addr = {5'd13, 5'd0};
    nxt(); idle();
    @(negedge clk);
    chk("no_uf_x0_or_both", 64'(err_underflow), 64'h0);
    chk("both_busy13", 64'(rd_busy[1]), 64'h0);
    nxt();

    we = 1; wb_retire = 1; wa = 12; wd = 32'h12;
    rd_addr = {5'd12, 5'd0};
    nxt(); idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("uf_sticky", 64'(err_underflow), 64'h1);
      chk("uf_busy12", 64'(rd_busy[1]), 64'h0);
      nxt();
    end

    rst = 1;
    nxt();
    rst = 0;
    rd_addr = {5'd7, 5'd0};
    issue_rd = 7;
    @(negedge clk);
    chk("rst_err", 64'(err_underflow), 64'h0);
    chk("rst_ready7", 64'(issue_ready), 64'h1);
    chk("rst_busy7", 64'(rd_busy[1]), 64'h0);
    we = 1; wb_retire = 1; wa = 7; wd = 32'h7;
    nxt(); idle();
    @(negedge clk);
    chk("post_rst_uf", 64'(err_underflow), 64'h1);
    nxt();

    chk_en = 0;
    rst = 1;
    nxt();
    rst = 0;
    bop(1, 3, 0, 0, '0);
    bop(1, 4, 0, 0, '0);
    @(negedge clk);
    chk("b_busy_mid", 64'(b_rd_busy), 64'h3);
    bop(0, 0, 1, 3, 64'h0123_4567_89AB_CDEF);
    bop(1, 6, 0, 0, '0);
    bop(1, 3, 1, 4, 64'h1111_2222_3333_4444);
    @(negedge clk);
    chk("b_busy_mid2", 64'(b_rd_busy), 64'h5);
    bop(0, 0, 1, 6, 64'hA5A5_5A5A_F0F0_0F0F);
    bop(0, 0, 1, 3, 64'hFEDC_BA98_7654_3210);
    bop(0, 0, 0, 0, '0);
    @(negedge clk);
    chk("b_busy_end", 64'(b_rd_busy), 64'h0);
    chk("b_ready_end", 64'(b_issue_ready), 64'h1);
    chk("b_err_end", 64'(b_err), 64'h0);
    chk("b_port0", b_rd_data[63:0], 64'hFEDC_BA98_7654_3210);
    chk("b_port1", b_rd_data[127:64], 64'h1111_2222_3333_4444);
    chk("b_port2", b_rd_data[191:128], 64'hA5A5_5A5A_F0F0_0F0F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised register file for the decode stage: NRD combinational read ports, one writeback port, x0 hardwired to zero, write-to-read bypass.
Adds a per-register pending-write scoreboard. Decode issues destination registers, writeback retires them, and the block reports per-port operand busy and issue readiness to the hazard logic.
Sits between instruction decode (read/issue side) and the writeback stage (write/retire side).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of 2, >=2)
NRD, 2, number of read ports
CNT_W, 2, width of per-register pending counter; max in-flight writes per register = 2^CNT_W-1
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
rd_addr  in  NRD*AW  read addresses; port i = bits [i*AW +: AW]
rd_data  out  NRD*XLEN  read data; port i = bits [i*XLEN +: XLEN]
rd_busy  out  NRD  port i operand still pending (consumer must stall)
we  in  1  writeback enable
wa  in  AW  writeback address
wd  in  XLEN  writeback data
wb_retire  in  1  writeback retires one scoreboard entry for wa (qualified by we)
issue_valid  in  1  decode issues an instruction writing issue_rd
issue_rd  in  AW  destination of issued instruction
issue_ready  out  1  issue is accepted this cycle
err_underflow  out  1  sticky: retire seen on register with zero count

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: all registers = 0, all counters = 0, err_underflow = 0. issue_ready = 1 and rd_busy = 0 in the cycle after reset. Reset mid-operation discards all pending state; in-flight retires after reset trigger underflow per the rules below.
- Register write: on posedge, if we && wa!=0, reg[wa] <= wd. Writes to x0 are ignored.
- Read: combinational, zero latency.
  - rd_data[i] = 0 if rd_addr[i]==0.
  - Else wd if we && wa==rd_addr[i] (bypass).
  - Else reg[rd_addr[i]].
- Counters: cnt[r], CNT_W bits; cnt[0] is constant 0.
- Issue acceptance: issue_acc = issue_valid && issue_ready.
  - issue_ready = 1 if issue_rd==0 or cnt[issue_rd] < 2^CNT_W-1.
  - issue_ready = 1 if cnt[issue_rd] is at max but we && wb_retire && wa==issue_rd this cycle (simultaneous retire frees a slot).
  - issue_ready is independent of issue_valid.
- Retire: ret = we && wb_retire && wa!=0.
- Counter update on posedge, per register r != 0:
  - issue_acc to r only: +1.
  - ret to r only: -1 if cnt>0. If cnt==0, cnt stays 0 and err_underflow <= 1.
  - Both issue_acc and ret to r: unchanged, including at cnt==0 (no underflow flagged).
  - Issue or retire to x0: no counter effect.
- we without wb_retire: writes data only; counters unaffected. Used for non-scoreboarded writes.
- Busy: rd_busy[i] = (rd_addr[i]!=0) && (cnt[rd_addr[i]] != 0).
  - Exception: rd_busy[i] = 0 if cnt==1 and ret to rd_addr[i] this cycle, since the last pending value arrives via bypass.
  - An issue in the same cycle does not affect busy for that cycle.
- err_underflow: cleared only by rst.
- Counters never wrap. Overflow is impossible because issue_ready gates acceptance.

Test Plan:
- Reset then read all ports at addr 0..31 -> rd_data=0, rd_busy=0, issue_ready=1, err_underflow=0.
- we=1, wa=5, wd=0xDEADBEEF, rd_addr0=5 in the same cycle -> rd_data0=0xDEADBEEF (bypass). Next cycle, we=0 -> still 0xDEADBEEF. Write wa=0, wd=0x1234 -> x0 reads 0.
- Issue rd=7 three times (CNT_W=2) -> cnt=3. Fourth issue_valid to 7 -> issue_ready=0. Same cycle with we&&wb_retire, wa=7 -> issue_ready=1, cnt stays 3.
- cnt[9]=1, rd_addr1=9, we&&wb_retire, wa=9, wd=0x55 -> rd_busy1=0, rd_data1=0x55. Next cycle cnt=0, rd_busy1=0.
- Retire wa=12 with cnt[12]=0 -> err_underflow=1, cnt stays 0. Holds until rst, then 0.
- NRD=3, XLEN=64 build: issue 3, retire 3 over a random interleave on three distinct registers -> all counters return to 0. 64-bit writes read back on all three ports.
